// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Captures the register-file operands and the decoded control bundle. Writeback
// data on the same cycle is bypassed around the register file. A load-use hazard
// inserts one bubble, stalls fetch/decode and is counted in a saturating counter.
module id_ex_stage #(
    parameter int unsigned CTRL_W      = 8,
    parameter int unsigned MEMREAD_BIT = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [CTRL_W-1:0]        id_ctrl,
    input  logic [4:0]               id_rs,
    input  logic [4:0]               id_rt,
    input  logic [4:0]               id_rd,
    input  logic [31:0]              id_imm,
    input  logic [31:0]              id_pc,
    input  logic signed [31:0]       rf_data1,
    input  logic signed [31:0]       rf_data2,
    input  logic                     wb_we,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    input  logic                     flush,
    input  logic                     hold,
    output logic                     ex_valid,
    output logic [CTRL_W-1:0]        ex_ctrl,
    output logic [4:0]               ex_rs,
    output logic [4:0]               ex_rt,
    output logic [4:0]               ex_rd,
    output logic [31:0]              ex_imm,
    output logic [31:0]              ex_pc,
    output logic signed [31:0]       ex_a,
    output logic signed [31:0]       ex_b,
    output logic                     stall,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam logic [4:0]       ZERO_REG = 5'd0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // What the stage does on the coming edge, in priority order.
    typedef enum logic [1:0] {
        UPD_CAPTURE,
        UPD_BUBBLE,
        UPD_HOLD,
        UPD_FLUSH
    } upd_e;

    // Pipeline registers and their next-state values.
    logic                    ex_valid_q,   ex_valid_d;
    logic [CTRL_W-1:0]       ex_ctrl_q,    ex_ctrl_d;
    logic [4:0]              ex_rs_q,      ex_rs_d;
    logic [4:0]              ex_rt_q,      ex_rt_d;
    logic [4:0]              ex_rd_q,      ex_rd_d;
    logic [31:0]             ex_imm_q,     ex_imm_d;
    logic [31:0]             ex_pc_q,      ex_pc_d;
    logic signed [31:0]      ex_a_q,       ex_a_d;
    logic signed [31:0]      ex_b_q,       ex_b_d;
    logic [CNT_W-1:0]        bubble_cnt_q, bubble_cnt_d;

    logic                    lu;
    logic                    byp_a;
    logic                    byp_b;
    logic signed [31:0]      op_a;
    logic signed [31:0]      op_b;
    upd_e                    upd;

    // Load-use hazard: a valid load in execute writes a register decode reads.
    always_comb begin
        lu = ex_valid_q
           & ex_ctrl_q[MEMREAD_BIT]
           & (ex_rt_q != ZERO_REG)
           & id_valid
           & ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));
    end

    // Operand bypass: same-cycle writeback beats the stale register-file read.
    // Register 0 is hard-wired to zero and is never bypassed.
    always_comb begin
        byp_a = wb_we & (wb_reg != ZERO_REG) & (wb_reg == id_rs);
        byp_b = wb_we & (wb_reg != ZERO_REG) & (wb_reg == id_rt);
        op_a  = byp_a ? $signed(wb_data) : rf_data1;
        op_b  = byp_b ? $signed(wb_data) : rf_data2;
    end

    // Pick the update kind: flush beats hold, hold beats load-use bubble.
    always_comb begin
        upd = UPD_CAPTURE;
        if (flush) begin
            upd = UPD_FLUSH;
        end else if (hold) begin
            upd = UPD_HOLD;
        end else if (lu) begin
            upd = UPD_BUBBLE;
        end
    end

    // Fetch/decode must stop while this stage freezes or inserts a bubble,
    // unless a redirect is squashing the decode instruction anyway.
    assign stall = (hold | lu) & ~flush;

    // Next-state for every pipeline register.
    always_comb begin
        // NOTE: every target gets its held value first so no path through the
        // case below can leave one unassigned and infer a latch.
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_rd_d      = ex_rd_q;
        ex_imm_d     = ex_imm_q;
        ex_pc_d      = ex_pc_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        bubble_cnt_d = bubble_cnt_q;

        case (upd)
            UPD_FLUSH: begin
                ex_valid_d = 1'b0;
            end
            UPD_HOLD: begin
                // Everything, including the valid bit, stays frozen.
            end
            UPD_BUBBLE: begin
                ex_valid_d = 1'b0;
                if (bubble_cnt_q != CNT_MAX) begin
                    bubble_cnt_d = bubble_cnt_q + CNT_ONE;
                end
            end
            UPD_CAPTURE: begin
                ex_valid_d = id_valid;
                ex_ctrl_d  = id_ctrl;
                ex_rs_d    = id_rs;
                ex_rt_d    = id_rt;
                ex_rd_d    = id_rd;
                ex_imm_d   = id_imm;
                ex_pc_d    = id_pc;
                ex_a_d     = op_a;
                ex_b_d     = op_b;
            end
            default: begin
            end
        endcase
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_imm_q     <= '0;
            ex_pc_q      <= '0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc_q      <= ex_pc_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;
    assign ex_imm     = ex_imm_q;
    assign ex_pc      = ex_pc_q;
    assign ex_a       = ex_a_q;
    assign ex_b       = ex_b_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage with a 2-bit bubble counter.
// Expected execute-slot contents are queued when a step is driven and
// compared after the following clock edge.
module tb_id_ex_stage;

    localparam int CTRL_W = 8;
    localparam int CNT_W  = 2;

    logic                clk;
    logic                rst_n;
    logic                id_valid;
    logic [CTRL_W-1:0]   id_ctrl;
    logic [4:0]          id_rs;
    logic [4:0]          id_rt;
    logic [4:0]          id_rd;
    logic [31:0]         id_imm;
    logic [31:0]         id_pc;
    logic signed [31:0]  rf_data1;
    logic signed [31:0]  rf_data2;
    logic                wb_we;
    logic [4:0]          wb_reg;
    logic [31:0]         wb_data;
    logic                flush;
    logic                hold;
    logic                ex_valid;
    logic [CTRL_W-1:0]   ex_ctrl;
    logic [4:0]          ex_rs;
    logic [4:0]          ex_rt;
    logic [4:0]          ex_rd;
    logic [31:0]         ex_imm;
    logic [31:0]         ex_pc;
    logic signed [31:0]  ex_a;
    logic signed [31:0]  ex_b;
    logic                stall;
    logic [CNT_W-1:0]    bubble_cnt;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [31:0]       imm;
        logic [31:0]       pc;
        logic [31:0]       a;
        logic [31:0]       b;
    } ex_t;

    ex_t              cur;
    ex_t              exp_q[$];
    logic [CNT_W-1:0] cnt_exp;
    logic [CNT_W-1:0] sat_tbl [5];
    int               checks;
    int               errors;

    id_ex_stage #(
        .CTRL_W      (CTRL_W),
        .MEMREAD_BIT (0),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ctrl    (id_ctrl),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_imm     (id_imm),
        .id_pc      (id_pc),
        .rf_data1   (rf_data1),
        .rf_data2   (rf_data2),
        .wb_we      (wb_we),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .flush      (flush),
        .hold       (hold),
        .ex_valid   (ex_valid),
        .ex_ctrl    (ex_ctrl),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .ex_imm     (ex_imm),
        .ex_pc      (ex_pc),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .stall      (stall),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic ex_t obs_ex();
        ex_t o;
        o.valid = ex_valid;
        o.ctrl  = ex_ctrl;
        o.rs    = ex_rs;
        o.rt    = ex_rt;
        o.rd    = ex_rd;
        o.imm   = ex_imm;
        o.pc    = ex_pc;
        o.a     = ex_a;
        o.b     = ex_b;
        return o;
    endfunction

    task automatic check(input string tag, input logic [151:0] obs, input logic [151:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [CTRL_W-1:0] c,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic [31:0] d1, input logic [31:0] d2);
        id_valid = v;
        id_ctrl  = c;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_imm   = imm;
        id_pc    = pc;
        rf_data1 = d1;
        rf_data2 = d2;
    endtask

    // Wait for the edge, then pop the oldest expectation and compare.
    task automatic tick(input string tag);
        ex_t e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, obs_ex(), e);
        check({tag, "_cnt"}, 152'(bubble_cnt), 152'(cnt_exp));
    endtask

    // Expect a normal capture of the driven decode fields with given operands.
    task automatic step_capture(input string tag, input logic [31:0] a_exp, input logic [31:0] b_exp);
        cur.valid = id_valid;
        cur.ctrl  = id_ctrl;
        cur.rs    = id_rs;
        cur.rt    = id_rt;
        cur.rd    = id_rd;
        cur.imm   = id_imm;
        cur.pc    = id_pc;
        cur.a     = a_exp;
        cur.b     = b_exp;
        exp_q.push_back(cur);
        tick(tag);
    endtask

    // Expect the execute fields to hold, with the given valid bit.
    task automatic step_keep(input string tag, input logic valid_exp);
        cur.valid = valid_exp;
        exp_q.push_back(cur);
        tick(tag);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cur     = '0;
        cnt_exp = '0;
        sat_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst_n   = 1'b0;
        flush   = 1'b0;
        hold    = 1'b0;
        wb_we   = 1'b0;
        wb_reg  = 5'd0;
        wb_data = 32'd0;
        set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Power-on reset state.
        #3;
        check("rst_ex", obs_ex(), cur);
        check("rst_cnt", 152'(bubble_cnt), 152'(cnt_exp));
        check("rst_stall", 152'(stall), 152'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Plain capture, no bypass.
        set_id(1'b1, 8'h02, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFF0, 32'h0000_0104, 32'h100, 32'h200);
        #1;
        check("cap_stall", 152'(stall), 152'(1'b0));
        step_capture("cap_basic", 32'h100, 32'h200);

        // Bypass on rs.
        set_id(1'b1, 8'h02, 5'd5, 5'd6, 5'd7, 32'h0000_0010, 32'h0000_0108, 32'h11, 32'h22);
        wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'h0000_ABCD;
        step_capture("byp_rs", 32'h0000_ABCD, 32'h22);

        // Register 0 never bypassed.
        set_id(1'b1, 8'h02, 5'd0, 5'd0, 5'd1, 32'h0000_0020, 32'h0000_010C, 32'h33, 32'h44);
        wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'h0000_ABCD;
        step_capture("byp_r0", 32'h33, 32'h44);

        // Bypass on rt only.
        set_id(1'b1, 8'h02, 5'd4, 5'd7, 5'd2, 32'h0000_0030, 32'h0000_0110, 32'h55, 32'h66);
        wb_we = 1'b1; wb_reg = 5'd7; wb_data = 32'h1234_5678;
        step_capture("byp_rt", 32'h55, 32'h1234_5678);
        wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;

        // Load-use: load writing r8 followed by a reader of r8.
        set_id(1'b1, 8'h01, 5'd9, 5'd8, 5'd0, 32'h0000_0004, 32'h0000_0114, 32'h70, 32'h80);
        step_capture("lu_load", 32'h70, 32'h80);
        set_id(1'b1, 8'h04, 5'd3, 5'd8, 5'd5, 32'h0000_0008, 32'h0000_0118, 32'h55, 32'h66);
        #1;
        check("lu_stall", 152'(stall), 152'(1'b1));
        cnt_exp = 2'd1;
        step_keep("lu_bubble", 1'b0);
        check("lu_stall_clear", 152'(stall), 152'(1'b0));
        step_capture("lu_resume", 32'h55, 32'h66);

        // Flush wins over load-use.
        set_id(1'b1, 8'h01, 5'd2, 5'd10, 5'd0, 32'h0000_000C, 32'h0000_011C, 32'h90, 32'hA0);
        step_capture("fl_load", 32'h90, 32'hA0);
        set_id(1'b1, 8'h00, 5'd10, 5'd3, 5'd7, 32'h0000_0014, 32'h0000_0120, 32'hB0, 32'hC0);
        flush = 1'b1;
        #1;
        check("fl_stall", 152'(stall), 152'(1'b0));
        step_keep("fl_lu", 1'b0);
        flush = 1'b0;
        step_capture("fl_resume", 32'hB0, 32'hC0);

        // Hold for three cycles with changing decode fields.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 8'h08, 5'(i + 11), 5'(i + 20), 5'(i + 1), 32'(i), 32'h200 + 32'(i), 32'(i + 1), 32'(i + 2));
            #1;
            check("hold_stall", 152'(stall), 152'(1'b1));
            step_keep("hold_frz", 1'b1);
        end
        hold = 1'b0;
        step_capture("hold_release", 32'd3, 32'd4);

        // Hold wins over load-use; the bubble follows once hold drops.
        set_id(1'b1, 8'h01, 5'd1, 5'd11, 5'd0, 32'h0000_0040, 32'h0000_0300, 32'hD0, 32'hE0);
        step_capture("hl_load", 32'hD0, 32'hE0);
        set_id(1'b1, 8'h00, 5'd11, 5'd0, 5'd9, 32'h0000_0044, 32'h0000_0304, 32'hF0, 32'hF1);
        hold = 1'b1;
        #1;
        check("hl_stall", 152'(stall), 152'(1'b1));
        step_keep("hl_frz", 1'b1);
        hold = 1'b0;
        #1;
        check("hl_lu_stall", 152'(stall), 152'(1'b1));
        cnt_exp = 2'd2;
        step_keep("hl_bubble", 1'b0);
        step_capture("hl_resume", 32'hF0, 32'hF1);

        // Asynchronous reset mid-stream, away from any edge.
        #2;
        rst_n = 1'b0;
        #1;
        cur     = '0;
        cnt_exp = '0;
        check("arst_ex", obs_ex(), cur);
        check("arst_cnt", 152'(bubble_cnt), 152'(cnt_exp));
        check("arst_stall", 152'(stall), 152'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1'b1, 8'h02, 5'd6, 5'd7, 5'd8, 32'h0000_0050, 32'h0000_0400, 32'h123, 32'h456);
        step_capture("arst_first", 32'h123, 32'h456);

        // Saturation of the 2-bit bubble counter.
        for (int k = 0; k < 5; k++) begin
            set_id(1'b1, 8'h01, 5'd0, 5'd12, 5'd0, 32'(k), 32'h500 + 32'(k), 32'(k), 32'(k + 100));
            step_capture("sat_load", 32'(k), 32'(k + 100));
            set_id(1'b1, 8'h00, 5'd12, 5'd1, 5'd2, 32'(k), 32'h600 + 32'(k), 32'h7, 32'h8);
            #1;
            check("sat_stall", 152'(stall), 152'(1'b1));
            cnt_exp = sat_tbl[k];
            step_keep("sat_bubble", 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the MIPS pipeline. It captures the two operands read asynchronously from the register file together with the decoded control bundle, and bypasses same-cycle writeback data around the register file. It detects load-use hazards, inserting a bubble and stalling fetch/decode when one occurs. It sits directly downstream of the register file's read ports and shares the writeback bus that drives the register file's write port.

## Interface
- CTRL_W, 8, width of decoded control bundle
- MEMREAD_BIT, 0, index in control bundle marking a load
- CNT_W, 16, width of bubble performance counter

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_ctrl  in  CTRL_W  decoded control bundle
- id_rs, id_rt, id_rd  in  5 each  register specifiers from decode
- id_imm  in  32  sign-extended immediate
- id_pc  in  32  PC+4 of decode instruction
- rf_data1, rf_data2  in  32 signed  register-file read data for id_rs / id_rt
- wb_we  in  1  writeback enable (same as register-file write enable)
- wb_reg  in  5  writeback destination
- wb_data  in  32  writeback data
- flush  in  1  branch/jump redirect: squash decode instruction
- hold  in  1  execute busy: freeze this stage
- ex_valid  out  1  execute slot valid
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- ex_imm, ex_pc  out  32 each  registered immediate / PC+4
- ex_a, ex_b  out  32 signed  registered operands
- stall  out  1  combinational: hold PC and IF/ID register this cycle
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles

## Operation
- Load-use hazard (combinational): `lu = ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt)`.
- Operand bypass: ex_a source = wb_data if `wb_we & wb_reg != 0 & wb_reg == id_rs`, else rf_data1. ex_b uses the same rule on id_rt / rf_data2. Register 0 is never bypassed.
- Per-edge update, in priority order:
  1. flush: ex_valid <= 0; the other fields are don't-care but hold their values.
  2. hold (no flush): every register keeps its value, including ex_valid.
  3. lu: ex_valid <= 0 (bubble); other fields hold; bubble_cnt increments.
  4. otherwise: capture all id_* fields and the bypassed operands; ex_valid <= id_valid.
- stall = (hold | lu) & ~flush.
- bubble_cnt: +1 per inserted load-use bubble; saturates at all-ones; never wraps. It does not count during hold or flush cycles.

## Timing
- Reset (asynchronous, rst_n low): all outputs 0, including ex_valid, bubble_cnt, and stall (stall follows from ex_valid = 0).
- Latency: one cycle from id_* to ex_*; outputs are registered. stall is the only combinational output.
- A write on wb_* in cycle N is visible in ex_a/ex_b at the edge ending cycle N, via the bypass. The register file itself shows the new value only from cycle N+1.
- Load-use costs exactly one bubble. The following cycle ex_valid = 0, so lu = 0 and the held decode instruction is captured. Its load value then arrives via later EX/MEM forwarding outside this block.
- flush and lu together: flush wins. stall = 0, no bubble is counted, ex_valid = 0.
- hold and lu together: hold wins. The stage freezes, stall = 1, and the counter does not increment.
- rst_n deassertion mid-operation must not glitch. The first edge after release performs a normal capture.

## Test plan
- Reset: drive rst_n = 0 mid-stream with ex_valid = 1 -> all outputs 0 immediately, without waiting for a clock edge; bubble_cnt = 0.
- Bypass: rf_data1 = 0x11, wb_we = 1, wb_reg = id_rs = 5, wb_data = 0xABCD -> ex_a = 0xABCD next cycle. Repeat with wb_reg = 0 and id_rs = 0 -> ex_a = rf_data1.
- Load-use: ex holds a load with ex_rt = 8; id_rt = 8, id_valid = 1 -> stall = 1 for one cycle, then ex_valid = 0 for one cycle, then the decode instruction is captured; bubble_cnt = 1.
- Flush precedence: flush = 1 with lu = 1 -> stall = 0, ex_valid = 0 next cycle, bubble_cnt unchanged.
- Hold: hold = 1 for 3 cycles with changing id_* -> ex_* constant and stall = 1 throughout; capture resumes on the first edge after hold drops.
- Saturation: CNT_W = 2, force 5 load-use bubbles -> bubble_cnt reads 1, 2, 3, 3, 3.
